gumnut_ctx_stack: RTL
=====================

GUMNUT_CTX_STACK -- requirements
Module: gumnut_ctx_stack

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving the return-address width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, giving the entry count; DEPTH is a power of 2 and at least 2.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port push_i  input  1  push request, sampled each cycle.
REQ-006 SHALL have port pop_i  input  1  pop request, sampled each cycle.
REQ-007 SHALL have port int_i  input  1  1 = interrupt frame (int/reti), 0 = call frame (jsb/ret); qualifies push_i and pop_i.
REQ-008 SHALL have port pc_i  input  ADDR_W  return address to save.
REQ-009 SHALL have ports z_i and c_i  input  1 each  condition flags to save.
REQ-010 SHALL have port top_pc_o  output  ADDR_W  PC of top entry, registered.
REQ-011 SHALL have ports top_z_o, top_c_o, top_int_o  output  1 each  flags and frame kind of top entry, registered.
REQ-012 SHALL have port level_o  output  $clog2(DEPTH+1)  current entry count.
REQ-013 SHALL have ports empty_o and full_o  output  1 each  level_o==0 and level_o==DEPTH, respectively.
REQ-014 SHALL have ports ovf_o, unf_o, mismatch_o  output  1 each  sticky error flags.

Function
REQ-015 An entry SHALL be {int_i, z_i, c_i, pc_i}, and storage SHALL be DEPTH entries addressed by a log2(DEPTH)-bit pointer that wraps modulo DEPTH.
REQ-016 A push (push_i=1, pop_i=0, not full) SHALL write the entry at the pointer, increment the pointer and level, and present the new entry on the top_* outputs on the next cycle.
REQ-017 A pop (pop_i=1, push_i=0, not empty) SHALL decrement the pointer and level, and present the entry below the old top on the top_* outputs on the next cycle.
REQ-018 When a pop leaves the stack empty, the top_* outputs SHALL read 0 on the next cycle.
REQ-019 A pop from an empty stack SHALL leave the pointer, level and top_* unchanged and SHALL set unf_o.
REQ-020 A pop whose int_i differs from top_int_o SHALL still complete and SHALL set mismatch_o (for example, a ret executed on an interrupt frame).
REQ-021 Simultaneous push and pop on a non-empty stack SHALL overwrite the top entry with the new entry, leave the level unchanged, and set the mismatch check per REQ-020.
REQ-022 Simultaneous push and pop on an empty stack SHALL behave as a push and SHALL set unf_o.
REQ-023 Push-when-full behaviour SHALL be as defined under Configuration.
REQ-024 ovf_o, unf_o and mismatch_o SHALL be sticky: once set, each holds until reset.
REQ-025 level_o, empty_o and full_o SHALL update on the same edge as the pointer.

Reset
REQ-026 While rst_i=1 at a rising edge, the pointer, level_o, all top_* outputs, ovf_o, unf_o and mismatch_o SHALL become 0, and empty_o SHALL become 1.
REQ-027 Reset SHALL take priority over simultaneous push_i or pop_i.
REQ-028 Storage contents SHALL NOT need a reset, and no reset-time content SHALL be observable.

Configuration
REQ-029 With GUMNUT_STACK_OVF_TRAP_EN defined, a push when full SHALL be dropped, leaving the pointer, level and top_* unchanged, and SHALL set ovf_o.
REQ-030 Without GUMNUT_STACK_OVF_TRAP_EN, a push when full SHALL overwrite the oldest entry (circular), advance the pointer, keep level_o=DEPTH, and present the new entry as top; ovf_o SHALL be constant 0.

Verification
REQ-031 Reset, then push pc=0x123/z=1/c=0/int=0 -> next cycle top_pc_o=0x123, top_z_o=1, level_o=1, empty_o=0.
REQ-032 With DEPTH=8, push 0x001..0x008 then pop 8 times -> top_pc_o reads 0x007,...,0x001,0 in turn, empty_o=1, no error flags set.
REQ-033 Pop on an empty stack -> unf_o=1, level_o=0, and unf_o remains 1 until rst_i.
REQ-034 With DEPTH=8, push 9 entries 0x001..0x009 -> with the macro: top_pc_o=0x008, ovf_o=1. Without the macro: top_pc_o=0x009, level_o=8, ovf_o=0, and 8 pops return 0x009..0x002.
REQ-035 Push an int=1 frame, then pop with int_i=0 -> mismatch_o=1 and level_o=0.
REQ-036 At level 3, assert push and pop together with pc=0x0AA -> level_o=3 and top_pc_o=0x0AA. Assert rst_i with push_i=1 -> level_o=0.

Source files
------------

// File: rtl/gumnut_ctx_stack.sv
// Return-address/flag context stack for the Gumnut core (jsb/ret and int/reti frames).
// Define GUMNUT_STACK_OVF_TRAP_EN to drop pushes when full and raise ovf_o; otherwise it wraps circularly.
module gumnut_ctx_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       int_i,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic                       z_i,
    input  logic                       c_i,
    output logic [ADDR_W-1:0]          top_pc_o,
    output logic                       top_z_o,
    output logic                       top_c_o,
    output logic                       top_int_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       ovf_o,
    output logic                       unf_o,
    output logic                       mismatch_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int EW    = ADDR_W + 3;

    logic [EW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [EW-1:0]    top_q;
    logic             unf_q;
    logic             mismatch_q;
    logic             empty;
    logic             full;
    logic [EW-1:0]    new_entry;
    logic [EW-1:0]    below_entry;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    assign empty       = (level_q == '0);
    assign full        = (level_q == LVL_W'(DEPTH));
    assign new_entry   = {int_i, z_i, c_i, pc_i};
    // ptr_q points at the next free slot, so the entry under the top sits two below it
    assign below_entry = mem[ptr_q - PTR_W'(2)];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        if (push_i && pop_i) begin
            wr_en = 1'b1;
            if (!empty) wr_addr = ptr_q - PTR_W'(1);
        end else if (push_i) begin
`ifdef GUMNUT_STACK_OVF_TRAP_EN
            wr_en = !full;
`else
            wr_en = 1'b1;
`endif
        end
    end

    // Storage is never reset; the top register masks its contents while empty.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) mem[wr_addr] <= new_entry;
    end

`ifdef GUMNUT_STACK_OVF_TRAP_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            level_q    <= '0;
            top_q      <= '0;
            unf_q      <= 1'b0;
            mismatch_q <= 1'b0;
`ifdef GUMNUT_STACK_OVF_TRAP_EN
            ovf_q      <= 1'b0;
`endif
        end else if (push_i && pop_i) begin
            top_q <= new_entry;
            if (empty) begin
                ptr_q   <= ptr_q + PTR_W'(1);
                level_q <= level_q + LVL_W'(1);
                unf_q   <= 1'b1;
            end else if (int_i != top_q[EW-1]) begin
                mismatch_q <= 1'b1;
            end
        end else if (push_i) begin
            if (!full) begin
                ptr_q   <= ptr_q + PTR_W'(1);
                level_q <= level_q + LVL_W'(1);
                top_q   <= new_entry;
            end else begin
`ifdef GUMNUT_STACK_OVF_TRAP_EN
                ovf_q <= 1'b1;
`else
                ptr_q <= ptr_q + PTR_W'(1);
                top_q <= new_entry;
`endif
            end
        end else if (pop_i) begin
            if (empty) begin
                unf_q <= 1'b1;
            end else begin
                ptr_q   <= ptr_q - PTR_W'(1);
                level_q <= level_q - LVL_W'(1);
                top_q   <= (level_q == LVL_W'(1)) ? '0 : below_entry;
                if (int_i != top_q[EW-1]) mismatch_q <= 1'b1;
            end
        end
    end

`ifdef GUMNUT_STACK_OVF_TRAP_EN
    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    assign top_int_o  = top_q[EW-1];
    assign top_z_o    = top_q[EW-2];
    assign top_c_o    = top_q[EW-3];
    assign top_pc_o   = top_q[ADDR_W-1:0];
    assign level_o    = level_q;
    assign empty_o    = empty;
    assign full_o     = full;
    assign unf_o      = unf_q;
    assign mismatch_o = mismatch_q;

endmodule
